// File: rtl/wired_rob_queue_pkg.sv
// wired_rob_queue_pkg: shared sizing defaults, payload typedefs and mask helpers
// for the Wired reorder buffer.
package wired_rob_queue_pkg;

    localparam int ROB_DEPTH    = 32;
    localparam int ROB_DISP_W   = 2;
    localparam int ROB_CDB_W    = 2;
    localparam int ROB_COMMIT_W = 2;
    localparam int ROB_STATIC_W = 64;
    localparam int ROB_DYN_W    = 48;
    localparam int ROB_DATA_W   = 32;

    typedef logic [$clog2(ROB_DEPTH)-1:0] rob_rid_t;
    typedef struct packed {logic [ROB_STATIC_W-1:0] bits;} rob_static_t;
    typedef struct packed {logic [ROB_DYN_W-1:0] bits;} rob_dyn_t;

    // True when the set bits of m form a contiguous run starting at bit 0.
    function automatic logic is_prefix(input logic [31:0] m);
        return ((m & (m + 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/wired_rob_prefix_cnt.sv
// wired_rob_prefix_cnt: per-lane count of set mask bits below each lane, plus the total.
module wired_rob_prefix_cnt #(
    parameter int N  = 2,
    parameter int CW = 2
) (
    input  logic [N-1:0]         mask,
    output logic [N-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc_s;

    // Running sum in lane order.
    always_comb begin
        acc_s = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc_s;
            acc_s     = acc_s + CW'(mask[i]);
        end
        total = acc_s;
    end

endmodule

// File: rtl/wired_rob_queue_chk.sv
// wired_rob_queue_chk: protocol checks on the commit handshake and occupancy.
module wired_rob_queue_chk
    import wired_rob_queue_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int CW       = 6,
    parameter int DEPTH    = 32
) (
    input logic                clk,
    input logic                rst_n,
    input logic [COMMIT_W-1:0] cm_valid,
    input logic [COMMIT_W-1:0] cm_retire,
    input logic [CW-1:0]       count
);

    // Retire must be a prefix subset of the presented entries.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ((cm_retire & ~cm_valid) == {COMMIT_W{1'b0}});
            assert (is_prefix(32'(cm_retire)));
            assert (count <= CW'(DEPTH));
        end
    end

endmodule

// File: rtl/wired_rob_queue.sv
// wired_rob_queue: reorder buffer with internal id allocation and in-order commit.
// Define WIRED_ROB_CDB_BYPASS_EN to forward same-cycle CDB writes into the commit view.
module wired_rob_queue
    import wired_rob_queue_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int DISP_W   = ROB_DISP_W,
    parameter int CDB_W    = ROB_CDB_W,
    parameter int COMMIT_W = ROB_COMMIT_W,
    parameter int STATIC_W = ROB_STATIC_W,
    parameter int DYN_W    = ROB_DYN_W,
    parameter int DATA_W   = ROB_DATA_W
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush_i,
    input  logic [DISP_W-1:0]                         disp_valid_i,
    input  logic [DISP_W-1:0][STATIC_W-1:0]           disp_static_i,
    output logic                                      disp_ready_o,
    output logic [DISP_W-1:0][$clog2(DEPTH)-1:0]      disp_rid_o,
    input  logic [CDB_W-1:0]                          cdb_valid_i,
    input  logic [CDB_W-1:0][$clog2(DEPTH)-1:0]       cdb_rid_i,
    input  logic [CDB_W-1:0][DATA_W-1:0]              cdb_data_i,
    input  logic [CDB_W-1:0][DYN_W-1:0]               cdb_dyn_i,
    output logic [COMMIT_W-1:0]                       cm_valid_o,
    output logic [COMMIT_W-1:0][STATIC_W-1:0]         cm_static_o,
    output logic [COMMIT_W-1:0][DYN_W-1:0]            cm_dyn_o,
    output logic [COMMIT_W-1:0][DATA_W-1:0]           cm_data_o,
    output logic [COMMIT_W-1:0][$clog2(DEPTH)-1:0]    cm_rid_o,
    input  logic [COMMIT_W-1:0]                       cm_retire_i,
    output logic [$clog2(DEPTH):0]                    count_o
);

    localparam int RW  = $clog2(DEPTH);
    localparam int CW  = RW + 1;
    localparam int DPW = $clog2(DISP_W + 1);
    localparam int MPW = $clog2(COMMIT_W + 1);

    logic [RW-1:0]       head_r, tail_r;
    logic [CW-1:0]       count_r;
    logic [DEPTH-1:0]    busy_r, done_r;
    logic [STATIC_W-1:0] static_mem_r [DEPTH];
    logic [DATA_W-1:0]   data_mem_r   [DEPTH];
    logic [DYN_W-1:0]    dyn_mem_r    [DEPTH];

    logic [DISP_W-1:0][DPW-1:0]   disp_off_s;
    logic [DPW-1:0]               disp_tot_s, ndisp_s;
    logic [COMMIT_W-1:0][MPW-1:0] ret_off_s;
    logic [MPW-1:0]               ret_tot_s;
    logic [COMMIT_W-1:0]          retire_s;
    logic                         disp_ready_s, disp_fire_s, prev_s, hit_s;
    logic [RW-1:0]                idx_s;
    logic [DATA_W-1:0]            byp_data_s;
    logic [DYN_W-1:0]             byp_dyn_s;
`ifdef WIRED_ROB_CDB_BYPASS_EN
    logic                         lane_hit_s;
`endif

    wired_rob_prefix_cnt #(.N(DISP_W), .CW(DPW)) u_disp_cnt (
        .mask   (disp_valid_i),
        .prefix (disp_off_s),
        .total  (disp_tot_s)
    );

    wired_rob_prefix_cnt #(.N(COMMIT_W), .CW(MPW)) u_ret_cnt (
        .mask   (retire_s),
        .prefix (ret_off_s),
        .total  (ret_tot_s)
    );

    // Space check uses registered count only, so same-cycle retires never free a slot early.
    assign disp_ready_s = (count_r <= CW'(DEPTH - DISP_W));
    assign disp_fire_s  = disp_ready_s && (|disp_valid_i) && !flush_i;
    assign ndisp_s      = disp_fire_s ? disp_tot_s : {DPW{1'b0}};
    assign retire_s     = cm_retire_i & cm_valid_o;
    assign disp_ready_o = disp_ready_s;
    assign count_o      = count_r;

    // Compacted id allocation: each lane gets tail plus the valid lanes ahead of it.
    always_comb begin
        for (int i = 0; i < DISP_W; i++) begin
            disp_rid_o[i] = tail_r + RW'(disp_off_s[i]);
        end
    end

    // Commit view: contiguous run of occupied, completed entries starting at head.
    always_comb begin
        cm_valid_o  = {COMMIT_W{1'b0}};
        prev_s      = 1'b1;
        hit_s       = 1'b0;
        idx_s       = head_r;
        byp_data_s  = {DATA_W{1'b0}};
        byp_dyn_s   = {DYN_W{1'b0}};
`ifdef WIRED_ROB_CDB_BYPASS_EN
        lane_hit_s  = 1'b0;
`endif
        for (int k = 0; k < COMMIT_W; k++) begin
            idx_s      = head_r + RW'(k);
            hit_s      = 1'b0;
            byp_data_s = data_mem_r[idx_s];
            byp_dyn_s  = dyn_mem_r[idx_s];
`ifdef WIRED_ROB_CDB_BYPASS_EN
            // Highest lane is evaluated last so it wins a same-id collision.
            for (int c = 0; c < CDB_W; c++) begin
                lane_hit_s = cdb_valid_i[c] && (cdb_rid_i[c] == idx_s) && busy_r[idx_s];
                hit_s      = hit_s | lane_hit_s;
                byp_data_s = lane_hit_s ? cdb_data_i[c] : byp_data_s;
                byp_dyn_s  = lane_hit_s ? cdb_dyn_i[c] : byp_dyn_s;
            end
`endif
            prev_s         = prev_s && (count_r > CW'(k)) && (done_r[idx_s] || hit_s);
            cm_valid_o[k]  = prev_s;
            cm_rid_o[k]    = idx_s;
            cm_static_o[k] = static_mem_r[idx_s];
            cm_data_o[k]   = byp_data_s;
            cm_dyn_o[k]    = byp_dyn_s;
        end
    end

    // Pointers, occupancy and per-entry busy/done; retire and dispatch override CDB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {RW{1'b0}};
            tail_r  <= {RW{1'b0}};
            count_r <= {CW{1'b0}};
            busy_r  <= {DEPTH{1'b0}};
            done_r  <= {DEPTH{1'b0}};
        end else if (flush_i) begin
            head_r  <= {RW{1'b0}};
            tail_r  <= {RW{1'b0}};
            count_r <= {CW{1'b0}};
            busy_r  <= {DEPTH{1'b0}};
            done_r  <= {DEPTH{1'b0}};
        end else begin
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_valid_i[c] && busy_r[cdb_rid_i[c]]) begin
                    done_r[cdb_rid_i[c]] <= 1'b1;
                end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (retire_s[k]) begin
                    busy_r[head_r + RW'(ret_off_s[k])] <= 1'b0;
                    done_r[head_r + RW'(ret_off_s[k])] <= 1'b0;
                end
            end
            for (int i = 0; i < DISP_W; i++) begin
                if (disp_fire_s && disp_valid_i[i]) begin
                    busy_r[disp_rid_o[i]] <= 1'b1;
                    done_r[disp_rid_o[i]] <= 1'b0;
                end
            end
            head_r  <= head_r + RW'(ret_tot_s);
            tail_r  <= tail_r + RW'(ndisp_s);
            count_r <= count_r + CW'(ndisp_s) - CW'(ret_tot_s);
        end
    end

    // Payload storage; not reset, only meaningful while the entry is busy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_W; i++) begin
            if (disp_fire_s && disp_valid_i[i]) begin
                static_mem_r[disp_rid_o[i]] <= disp_static_i[i];
            end
        end
        for (int c = 0; c < CDB_W; c++) begin
            if (!flush_i && cdb_valid_i[c] && busy_r[cdb_rid_i[c]]) begin
                data_mem_r[cdb_rid_i[c]] <= cdb_data_i[c];
                dyn_mem_r[cdb_rid_i[c]]  <= cdb_dyn_i[c];
            end
        end
    end

    wired_rob_queue_chk #(.COMMIT_W(COMMIT_W), .CW(CW), .DEPTH(DEPTH)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .cm_valid  (cm_valid_o),
        .cm_retire (cm_retire_i),
        .count     (count_r)
    );

endmodule
